// File: rtl/imm_gen_pipe.sv
// Pipelined immediate generator: decodes the RV immediate and PC-relative target on the
// input side, then registers the beat through a 2-entry (MAIN + SKID) elastic stage so
// that back-pressure never costs throughput.
module imm_gen_pipe #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned TAG_W = 8
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [31:0]      i_instr,
    input  logic [XLEN-1:0]  i_pc,
    input  logic [TAG_W-1:0] i_tag,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [XLEN-1:0]  o_imm,
    output logic [2:0]       o_type,
    output logic [XLEN-1:0]  o_target,
    output logic [TAG_W-1:0] o_tag
);

    localparam logic [2:0] TypeNone  = 3'd0;
    localparam logic [2:0] TypeI     = 3'd1;
    localparam logic [2:0] TypeS     = 3'd2;
    localparam logic [2:0] TypeB     = 3'd3;
    localparam logic [2:0] TypeU     = 3'd4;
    localparam logic [2:0] TypeJ     = 3'd5;
    localparam logic [2:0] TypeShamt = 3'd6;

    typedef enum logic [1:0] {
        StEmpty,
        StFull,
        StTwo
    } state_e;

    typedef struct packed {
        logic [TAG_W-1:0] tag;
        logic [XLEN-1:0]  target;
        logic [2:0]       typ;
        logic [XLEN-1:0]  imm;
    } beat_t;

    state_e state_q, state_d;
    beat_t  main_q, main_d;
    beat_t  skid_q, skid_d;
    beat_t  dec;

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       is_shift;
    logic       use_pc;
    logic       in_fire;
    logic       out_fire;

    assign opcode   = i_instr[6:0];
    assign funct3   = i_instr[14:12];
    assign is_shift = (funct3 == 3'b001) || (funct3 == 3'b101);

    // Decode the incoming instruction into a complete output beat.
    always_comb begin
        dec     = '0;
        use_pc  = 1'b0;
        dec.tag = i_tag;
        unique case (opcode)
            7'b0010011: begin
                if (is_shift) begin
                    dec.typ = TypeShamt;
                    // RV64 shifts use a 6-bit shamt; RV32 only 5 bits.
                    if (XLEN == 64) dec.imm = XLEN'(i_instr[25:20]);
                    else            dec.imm = XLEN'(i_instr[24:20]);
                end else begin
                    dec.typ = TypeI;
                    dec.imm = XLEN'($signed(i_instr[31:20]));
                end
            end
            7'b0000011, 7'b1100111: begin
                // jalr target depends on rs1, which is not visible here.
                dec.typ = TypeI;
                dec.imm = XLEN'($signed(i_instr[31:20]));
            end
            7'b0100011: begin
                dec.typ = TypeS;
                dec.imm = XLEN'($signed({i_instr[31:25], i_instr[11:7]}));
            end
            7'b1100011: begin
                dec.typ = TypeB;
                dec.imm = XLEN'($signed({i_instr[31], i_instr[7], i_instr[30:25],
                                         i_instr[11:8], 1'b0}));
                use_pc  = 1'b1;
            end
            7'b1101111: begin
                dec.typ = TypeJ;
                dec.imm = XLEN'($signed({i_instr[31], i_instr[19:12], i_instr[20],
                                         i_instr[30:21], 1'b0}));
                use_pc  = 1'b1;
            end
            7'b0110111, 7'b0010111: begin
                dec.typ = TypeU;
                dec.imm = XLEN'($signed({i_instr[31:12], 12'b0}));
                use_pc  = (opcode == 7'b0010111);
            end
            7'b0011011: begin
                // OP-IMM-32 exists only on RV64; W-shifts always use a 5-bit shamt.
                if (XLEN == 64) begin
                    if (is_shift) begin
                        dec.typ = TypeShamt;
                        dec.imm = XLEN'(i_instr[24:20]);
                    end else begin
                        dec.typ = TypeI;
                        dec.imm = XLEN'($signed(i_instr[31:20]));
                    end
                end
            end
            default: begin
                dec.typ = TypeNone;
            end
        endcase
        dec.target = use_pc ? (i_pc + dec.imm) : '0;
    end

    assign o_valid  = (state_q != StEmpty);
    assign o_ready  = (state_q != StTwo);
    assign in_fire  = i_valid && o_ready;
    assign out_fire = o_valid && i_ready;

    assign o_imm    = main_q.imm;
    assign o_type   = main_q.typ;
    assign o_target = main_q.target;
    assign o_tag    = main_q.tag;

    // Next-state and storage steering for the MAIN/SKID pair.
    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        unique case (state_q)
            StEmpty: begin
                if (in_fire) begin
                    main_d  = dec;
                    state_d = StFull;
                end
            end
            StFull: begin
                if (in_fire && out_fire) begin
                    main_d = dec;
                end else if (out_fire) begin
                    state_d = StEmpty;
                end else if (in_fire) begin
                    skid_d  = dec;
                    state_d = StTwo;
                end
            end
            StTwo: begin
                if (out_fire) begin
                    main_d  = skid_q;
                    state_d = StFull;
                end
            end
            default: begin
                state_d = StEmpty;
            end
        endcase
    end

    // State and beat registers; reset discards any held beats.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q <= StEmpty;
            main_q  <= '0;
            skid_q  <= '0;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
        end
    end

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Self-checking bench: one XLEN=32 and one XLEN=64 instance share stimulus; a decode table
// checks both, then hand-written sequences cover back-pressure and reset while full.
module tb_imm_gen_pipe;

    logic        clk;
    logic        rst;
    logic        valid;
    logic        ready;
    logic [31:0] instr;
    logic [63:0] pc;
    logic [7:0]  tag;

    logic        o_ready32, o_valid32, o_ready64, o_valid64;
    logic [31:0] imm32, tgt32;
    logic [63:0] imm64, tgt64;
    logic [2:0]  type32, type64;
    logic [7:0]  tag32, tag64;

    int checks;
    int failures;

    imm_gen_pipe #(.XLEN(32), .TAG_W(8)) dut32 (
        .i_clk    (clk),
        .i_reset  (rst),
        .i_valid  (valid),
        .o_ready  (o_ready32),
        .i_instr  (instr),
        .i_pc     (pc[31:0]),
        .i_tag    (tag),
        .o_valid  (o_valid32),
        .i_ready  (ready),
        .o_imm    (imm32),
        .o_type   (type32),
        .o_target (tgt32),
        .o_tag    (tag32)
    );

    imm_gen_pipe #(.XLEN(64), .TAG_W(8)) dut64 (
        .i_clk    (clk),
        .i_reset  (rst),
        .i_valid  (valid),
        .o_ready  (o_ready64),
        .i_instr  (instr),
        .i_pc     (pc),
        .i_tag    (tag),
        .o_valid  (o_valid64),
        .i_ready  (ready),
        .o_imm    (imm64),
        .o_type   (type64),
        .o_target (tgt64),
        .o_tag    (tag64)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [31:0] instr;
        logic [63:0] pc;
        logic [31:0] imm32;
        logic [2:0]  ty32;
        logic [31:0] tgt32;
        logic [63:0] imm64;
        logic [2:0]  ty64;
        logic [63:0] tgt64;
    } vec_t;

    vec_t vecs[13];

    initial begin
        int cnt;
        int next_tag;
        int got;
        int exp_q[$];
        logic in_f;
        logic out_f;

        checks   = 0;
        failures = 0;

        // beq 0xFE000EE3: bit fields give imm = -4, so target = 0x200 - 4.
        vecs[0]  = '{32'hFFF00093, 64'h100,  32'hFFFFFFFF, 3'd1, 32'h0,
                     64'hFFFFFFFFFFFFFFFF, 3'd1, 64'h0};
        vecs[1]  = '{32'hFE000EE3, 64'h200,  32'hFFFFFFFC, 3'd3, 32'h1FC,
                     64'hFFFFFFFFFFFFFFFC, 3'd3, 64'h1FC};
        vecs[2]  = '{32'h03F09093, 64'h0,    32'h1F,       3'd6, 32'h0,
                     64'h3F, 3'd6, 64'h0};
        vecs[3]  = '{32'h800000B7, 64'h0,    32'h80000000, 3'd4, 32'h0,
                     64'hFFFFFFFF80000000, 3'd4, 64'h0};
        vecs[4]  = '{32'h80000097, 64'h10,   32'h80000000, 3'd4, 32'h80000010,
                     64'hFFFFFFFF80000000, 3'd4, 64'hFFFFFFFF80000010};
        vecs[5]  = '{32'hFE20AC23, 64'h0,    32'hFFFFFFF8, 3'd2, 32'h0,
                     64'hFFFFFFFFFFFFFFF8, 3'd2, 64'h0};
        vecs[6]  = '{32'h0010006F, 64'h1000, 32'h800,      3'd5, 32'h1800,
                     64'h800, 3'd5, 64'h1800};
        vecs[7]  = '{32'h00C08067, 64'h40,   32'hC,        3'd1, 32'h0,
                     64'hC, 3'd1, 64'h0};
        vecs[8]  = '{32'h01F0909B, 64'h0,    32'h0,        3'd0, 32'h0,
                     64'h1F, 3'd6, 64'h0};
        vecs[9]  = '{32'hFFF0809B, 64'h0,    32'h0,        3'd0, 32'h0,
                     64'hFFFFFFFFFFFFFFFF, 3'd1, 64'h0};
        vecs[10] = '{32'h00000033, 64'h80,   32'h0,        3'd0, 32'h0,
                     64'h0, 3'd0, 64'h0};
        vecs[11] = '{32'h4050D093, 64'h0,    32'h5,        3'd6, 32'h0,
                     64'h5, 3'd6, 64'h0};
        vecs[12] = '{32'hFF1FF06F, 64'h8,    32'hFFFFFFF0, 3'd5, 32'hFFFFFFF8,
                     64'hFFFFFFFFFFFFFFF0, 3'd5, 64'hFFFFFFFFFFFFFFF8};

        rst   = 1'b1;
        valid = 1'b0;
        ready = 1'b1;
        instr = 32'h0;
        pc    = 64'h0;
        tag   = 8'h0;
        repeat (2) step();
        check("rst o_valid", {63'b0, o_valid32}, 64'd0);
        check("rst o_ready", {63'b0, o_ready32}, 64'd1);
        check("rst o_imm",   {32'b0, imm32},     64'd0);
        check("rst o_type",  {61'b0, type32},    64'd0);
        check("rst o_target", tgt64,             64'd0);
        check("rst o_tag",   {56'b0, tag64},     64'd0);
        rst = 1'b0;
        step();

        // Back-to-back decode table, downstream always ready.
        for (int i = 0; i < 13; i++) begin
            valid = 1'b1;
            instr = vecs[i].instr;
            pc    = vecs[i].pc;
            tag   = 8'(i + 1);
            step();
            check($sformatf("v%0d valid", i), {63'b0, o_valid32 & o_valid64}, 64'd1);
            check($sformatf("v%0d imm32", i),  {32'b0, imm32},  {32'b0, vecs[i].imm32});
            check($sformatf("v%0d type32", i), {61'b0, type32}, {61'b0, vecs[i].ty32});
            check($sformatf("v%0d tgt32", i),  {32'b0, tgt32},  {32'b0, vecs[i].tgt32});
            check($sformatf("v%0d tag32", i),  {56'b0, tag32},  64'(i + 1));
            check($sformatf("v%0d imm64", i),  imm64,           vecs[i].imm64);
            check($sformatf("v%0d type64", i), {61'b0, type64}, {61'b0, vecs[i].ty64});
            check($sformatf("v%0d tgt64", i),  tgt64,           vecs[i].tgt64);
            check($sformatf("v%0d tag64", i),  {56'b0, tag64},  64'(i + 1));
        end
        valid = 1'b0;
        step();
        check("drain o_valid", {63'b0, o_valid32}, 64'd0);

        // Back-pressure: tags 1..4 offered back to back, downstream stalled for 3 cycles.
        cnt      = 0;
        next_tag = 1;
        got      = 0;
        instr    = 32'h00100093;
        pc       = 64'h0;
        for (int cyc = 0; cyc < 20 && got < 4; cyc++) begin
            ready = (cyc >= 3);
            valid = (next_tag <= 4);
            tag   = 8'(next_tag);
            #1;
            check($sformatf("bp c%0d o_ready", cyc), {63'b0, o_ready32}, {63'b0, cnt < 2});
            check($sformatf("bp c%0d o_valid", cyc), {63'b0, o_valid32}, {63'b0, cnt > 0});
            if (cnt > 0) begin
                check($sformatf("bp c%0d tag32", cyc), {56'b0, tag32}, 64'(exp_q[0]));
                check($sformatf("bp c%0d tag64", cyc), {56'b0, tag64}, 64'(exp_q[0]));
            end
            in_f  = valid && (cnt < 2);
            out_f = ready && (cnt > 0);
            if (out_f) begin
                void'(exp_q.pop_front());
                got++;
            end
            if (in_f) begin
                exp_q.push_back(next_tag);
                next_tag++;
            end
            cnt = cnt + int'(in_f) - int'(out_f);
            step();
        end
        check("bp beats out", 64'(got), 64'd4);
        valid = 1'b0;
        step();
        check("bp empty", {63'b0, o_valid32}, 64'd0);

        // Reset while both MAIN and SKID are occupied.
        ready = 1'b0;
        valid = 1'b1;
        tag   = 8'd9;
        step();
        tag = 8'd10;
        step();
        valid = 1'b0;
        check("two o_ready", {63'b0, o_ready32}, 64'd0);
        #2 rst = 1'b1;
        #1;
        check("midrst o_valid", {62'b0, o_valid32, o_valid64}, 64'd0);
        check("midrst o_ready", {62'b0, o_ready32, o_ready64}, 64'd3);
        check("midrst o_tag",   {56'b0, tag32},  64'd0);
        check("midrst o_imm",   imm64,           64'd0);
        @(posedge clk);
        #3 rst = 1'b0;
        @(negedge clk);
        ready = 1'b1;
        valid = 1'b1;
        instr = 32'hFFF00093;
        tag   = 8'd11;
        step();
        valid = 1'b0;
        check("post o_valid", {63'b0, o_valid32}, 64'd1);
        check("post o_tag",   {56'b0, tag32},     64'd11);
        check("post o_imm",   {32'b0, imm32},     64'hFFFFFFFF);
        step();
        check("post alone", {62'b0, o_valid32, o_valid64}, 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
